// File: rtl/zeroriscy_multdiv_iter.sv
// Iterative 32-bit multiply/divide unit that does every addition on the ALU's shared adder.
// Define ZERORISCY_MULTDIV_DIV_EN to build the restoring divider; without it, DIV/REM finish immediately with 0.
module zeroriscy_multdiv_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mult_en_i,
    input  logic        div_en_i,
    input  logic [1:0]  operator_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [33:0] alu_adder_ext_i,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    output logic        multdiv_en_o,
    output logic [31:0] multdiv_result_o,
    output logic        ready_o
);

    typedef enum logic [2:0] {
        IDLE,
        ABS_A,
        ABS_B,
        COMP,
        CHANGE_SIGN,
        FINISH
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_hi;
    logic [31:0] r_result;

    logic        w_req;
    logic        w_is_div;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_add_x;
    logic [31:0] w_add_y;
    logic        w_add_cin;
    logic [31:0] w_sum;
    logic        w_carry;
    logic        w_unused_ext0;
    logic        w_res_neg;
    logic [31:0] w_res_word;

    assign w_req         = mult_en_i | div_en_i;
    assign multdiv_en_o  = w_req;
    assign w_neg_a       = signed_mode_i[0] & op_a_i[31];
    assign w_neg_b       = signed_mode_i[1] & op_b_i[31];

    assign alu_operand_a_o = {w_add_x, 1'b1};
    assign alu_operand_b_o = {w_add_y, w_add_cin};
    assign w_sum           = alu_adder_ext_i[32:1];
    assign w_carry         = alu_adder_ext_i[33];
    assign w_unused_ext0   = alu_adder_ext_i[0];

    assign ready_o          = (r_state == FINISH);
    assign multdiv_result_o = (r_state == FINISH) ? r_result : 32'd0;

`ifdef ZERORISCY_MULTDIV_DIV_EN
    logic [31:0] w_rem_shift;
    logic        w_keep;

    assign w_is_div    = div_en_i;
    assign w_rem_shift = {r_hi[30:0], r_op_a[31]};
    // A remainder bit shifted out of r_hi means the partial remainder already exceeds any 32-bit divisor.
    assign w_keep      = w_carry | r_hi[31];
`else
    assign w_is_div    = 1'b0;
`endif

    always_comb begin
        w_add_x   = 32'd0;
        w_add_y   = 32'd0;
        w_add_cin = 1'b0;
        case (r_state)
            ABS_A: begin
                w_add_x   = ~op_a_i;
                w_add_cin = 1'b1;
            end
            ABS_B: begin
                w_add_x   = ~op_b_i;
                w_add_cin = 1'b1;
            end
            COMP: begin
`ifdef ZERORISCY_MULTDIV_DIV_EN
                if (w_is_div) begin
                    w_add_x   = w_rem_shift;
                    w_add_y   = ~r_op_b;
                    w_add_cin = 1'b1;
                end else begin
                    w_add_x = r_hi;
                    w_add_y = r_op_a[0] ? r_op_b : 32'd0;
                end
`else
                w_add_x = r_hi;
                w_add_y = r_op_a[0] ? r_op_b : 32'd0;
`endif
            end
            CHANGE_SIGN: begin
                case (operator_i)
                    OP_MUL: begin
                        w_add_x   = ~r_op_a;
                        w_add_cin = 1'b1;
                    end
                    OP_MULH: begin
                        w_add_x   = ~r_hi;
                        w_add_cin = (r_op_a == 32'd0);
                    end
                    OP_DIV: begin
                        w_add_x   = ~r_op_a;
                        w_add_cin = 1'b1;
                    end
                    OP_REM: begin
                        w_add_x   = ~r_hi;
                        w_add_cin = 1'b1;
                    end
                endcase
            end
            default: begin
                w_add_x   = 32'd0;
                w_add_y   = 32'd0;
                w_add_cin = 1'b0;
            end
        endcase
    end

    // Division by zero must return all-ones quotient, so its sign fix-up is suppressed.
    always_comb begin
        w_res_neg  = 1'b0;
        w_res_word = r_op_a;
        case (operator_i)
            OP_MUL: begin
                w_res_neg  = w_neg_a ^ w_neg_b;
                w_res_word = r_op_a;
            end
            OP_MULH: begin
                w_res_neg  = w_neg_a ^ w_neg_b;
                w_res_word = r_hi;
            end
            OP_DIV: begin
                w_res_neg  = (w_neg_a ^ w_neg_b) & (r_op_b != 32'd0);
                w_res_word = r_op_a;
            end
            OP_REM: begin
                w_res_neg  = w_neg_a;
                w_res_word = r_hi;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_count  <= 5'd0;
            r_op_a   <= 32'd0;
            r_op_b   <= 32'd0;
            r_hi     <= 32'd0;
            r_result <= 32'd0;
        end else if (!w_req && r_state != IDLE && r_state != FINISH) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_result <= 32'd0;
`ifdef ZERORISCY_MULTDIV_DIV_EN
                        r_state  <= ABS_A;
`else
                        r_state  <= div_en_i ? FINISH : ABS_A;
`endif
                    end
                end
                ABS_A: begin
                    r_op_a  <= w_neg_a ? w_sum : op_a_i;
                    r_hi    <= 32'd0;
                    r_state <= ABS_B;
                end
                ABS_B: begin
                    r_op_b  <= w_neg_b ? w_sum : op_b_i;
                    r_count <= 5'd0;
                    r_state <= COMP;
                end
                COMP: begin
`ifdef ZERORISCY_MULTDIV_DIV_EN
                    if (w_is_div) begin
                        r_hi   <= w_keep ? w_sum : w_rem_shift;
                        r_op_a <= {r_op_a[30:0], w_keep};
                    end else begin
                        r_hi   <= {w_carry, w_sum[31:1]};
                        r_op_a <= {w_sum[0], r_op_a[31:1]};
                    end
`else
                    r_hi   <= {w_carry, w_sum[31:1]};
                    r_op_a <= {w_sum[0], r_op_a[31:1]};
`endif
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= CHANGE_SIGN;
                    end
                end
                CHANGE_SIGN: begin
                    r_result <= w_res_neg ? w_sum : w_res_word;
                    r_state  <= FINISH;
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
